// File: rtl/alu_pkg.sv
// Shared definitions for the SAP-2 ALU and its sequencer: op codes, sequencer
// state encoding and op classification.
package alu_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_AND = 3'd2;
  localparam logic [OP_W-1:0] OP_OR  = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR = 3'd4;
  localparam logic [OP_W-1:0] OP_CMA = 3'd5;
  localparam logic [OP_W-1:0] OP_RAL = 3'd6;
  localparam logic [OP_W-1:0] OP_RAR = 3'd7;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StExec,
    StDone
  } seq_state_e;

  // Binary ops need TMP loaded from the bus; unary ops work on A alone.
  function automatic logic is_binary(input logic [OP_W-1:0] op);
    return op <= OP_XOR;
  endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Multi-cycle controller for the SAP-2 ALU. Owns the accumulator and Z/S flags,
// accepts one command per valid/ready handshake, loads TMP for binary ops and
// repeats unary ops a programmable number of times.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned BUS_W  = 16,
  parameter int unsigned CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [2:0]        cmd_op_i,
  input  logic [DATA_W-1:0] cmd_operand_i,
  input  logic [CNT_W-1:0]  cmd_count_i,
  input  logic              acc_wr_i,
  input  logic [DATA_W-1:0] acc_wdata_i,
  output logic [2:0]        alu_op_o,
  output logic              alu_load_o,
  output logic [BUS_W-1:0]  bus_out_o,
  output logic [DATA_W-1:0] alu_a_o,
  input  logic [DATA_W-1:0] alu_result_i,
  output logic [DATA_W-1:0] acc_o,
  output logic              flag_z_o,
  output logic              flag_s_o,
  output logic              done_o
);

  seq_state_e        state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              flag_z_q, flag_z_d;
  logic              flag_s_q, flag_s_d;
  logic [2:0]        op_q, op_d;
  logic [DATA_W-1:0] operand_q, operand_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic              done_q, done_d;
  logic              alu_load_q, alu_load_d;
  logic [BUS_W-1:0]  bus_out_q, bus_out_d;
  logic              accept;

  assign accept = cmd_valid_i && (state_q == StIdle);

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    flag_z_d    = flag_z_q;
    flag_s_d    = flag_s_q;
    op_d        = op_q;
    operand_d   = operand_q;
    remaining_d = remaining_q;

    unique case (state_q)
      StIdle: begin
        // A same-cycle write lands first so the command operates on it.
        if (acc_wr_i) begin
          acc_d = acc_wdata_i;
        end
        if (accept) begin
          op_d      = cmd_op_i;
          operand_d = cmd_operand_i;
          if (is_binary(cmd_op_i)) begin
            state_d = StLoad;
          end else begin
            state_d     = StExec;
            remaining_d = (cmd_count_i == '0) ? CNT_W'(1) : cmd_count_i;
          end
        end
      end
      StLoad: begin
        state_d     = StExec;
        remaining_d = CNT_W'(1);
      end
      StExec: begin
        acc_d       = alu_result_i;
        remaining_d = remaining_q - CNT_W'(1);
        // Flags reflect only the final iteration.
        if (remaining_q == CNT_W'(1)) begin
          flag_z_d = (alu_result_i == '0);
          flag_s_d = alu_result_i[DATA_W-1];
          state_d  = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Outputs are registered from the next state so they are glitch free.
    done_d     = (state_d == StDone);
    alu_load_d = (state_d == StLoad);
    bus_out_d  = (state_d == StLoad) ? {{(BUS_W-DATA_W){1'b0}}, operand_d} : '0;
  end

  // State and datapath registers; reset abandons any command in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      flag_z_q    <= 1'b0;
      flag_s_q    <= 1'b0;
      op_q        <= '0;
      operand_q   <= '0;
      remaining_q <= '0;
      done_q      <= 1'b0;
      alu_load_q  <= 1'b0;
      bus_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      flag_z_q    <= flag_z_d;
      flag_s_q    <= flag_s_d;
      op_q        <= op_d;
      operand_q   <= operand_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
      alu_load_q  <= alu_load_d;
      bus_out_q   <= bus_out_d;
    end
  end

  assign cmd_ready_o = (state_q == StIdle);
  assign alu_op_o    = op_q;
  assign alu_a_o     = acc_q;
  assign alu_load_o  = alu_load_q;
  assign bus_out_o   = bus_out_q;
  assign acc_o       = acc_q;
  assign flag_z_o    = flag_z_q;
  assign flag_s_o    = flag_s_q;
  assign done_o      = done_q;

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle controller that sequences the SAP-2 ALU (8-bit A input, TMP register loaded from the 16-bit bus, 3-bit op select, combinational result).
- Owns the accumulator and Z/S flags.
- Accepts one command per valid/ready handshake, loads TMP for binary ops, and iterates unary ops (CMA/RAL/RAR) a programmable number of times.
- Sits between the CPU control unit and the ALU instance.

Parameters:
- DATA_W, 8, accumulator/operand width; must match the ALU.
- BUS_W, 16, system bus width driven toward the ALU TMP load.
- CNT_W, 3, width of the unary repeat count.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  controller can accept a command
- cmd_op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 CMA, 6 RAL, 7 RAR
- cmd_operand  in  DATA_W  TMP operand for binary ops; ignored for unary ops
- cmd_count  in  CNT_W  repeat count for unary ops; 0 treated as 1; ignored for binary ops
- acc_wr  in  1  direct accumulator write, honoured in IDLE only
- acc_wdata  in  DATA_W  direct write data
- alu_op  out  3  op select to ALU
- alu_load  out  1  TMP load strobe to ALU
- bus_out  out  BUS_W  bus value for TMP load
- alu_a  out  DATA_W  accumulator value driven to ALU A input
- alu_result  in  DATA_W  ALU combinational output
- acc  out  DATA_W  accumulator
- flag_z  out  1  result zero
- flag_s  out  1  result bit 7
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset: rst, asynchronous, active-high; clock clk.
  - Reset sets state=IDLE and acc, flags, op_q, operand_q, remaining counter, done, alu_load and bus_out to 0.
  - cmd_ready=1 after reset.
  - Reset mid-command abandons the command with no done pulse.
- alu_a = acc continuously. alu_op = op_q (registered) continuously.
- bus_out = {zeros, operand_q} only in LOAD, else 0. alu_load = 1 only in LOAD.
- cmd_ready = 1 only in IDLE. A command is accepted on a clock edge with cmd_valid & cmd_ready.
- States:
  - IDLE
    - On accept, latch op_q and operand_q.
    - op<=4: go to LOAD.
    - Else go to EXEC with remaining = (cmd_count==0 ? 1 : cmd_count).
  - LOAD
    - One cycle. ALU captures TMP at the end of this cycle.
    - Next state EXEC with remaining=1.
  - EXEC
    - Each cycle: acc <= alu_result and remaining decrements.
    - remaining==1: update flag_z = (alu_result==0) and flag_s = alu_result[7], then go to DONE.
    - Otherwise stay in EXEC. Flags are not touched on intermediate iterations.
  - DONE
    - done=1 for exactly this cycle; cmd_ready=0.
    - Next state IDLE.
- Latency, counted from the accept edge:
  - Binary op: LOAD cycle, EXEC cycle, DONE cycle; result in acc at the end of EXEC (edge 2); next accept possible at edge 4.
  - Unary op with count N: N EXEC cycles, then DONE.
- Arithmetic: mod 2^8 wrap. No carry flag. RAR is logical (bit 7 fills with 0). RAL rotates bit 7 into bit 0.
- acc_wr:
  - Writes acc in IDLE. Flags unchanged.
  - acc_wr in the same IDLE cycle as an accept: both take effect, and the command operates on acc_wdata.
  - acc_wr outside IDLE is ignored.
- cmd_valid while not ready: no effect. The requester holds the command until accepted.

Decomposition:
- Package alu_pkg holds:
  - the op code localparams (OP_ADD..OP_RAR), shared with the ALU;
  - the state encoding (IDLE, LOAD, EXEC, DONE);
  - an is_binary(op) function.
- No sub-module is needed. The ALU instance stays at the parent level, wired to alu_op/alu_load/bus_out/alu_a/alu_result.

Test Plan:
- Reset mid-EXEC of a RAL count 5 -> acc=0, flags=0, cmd_ready=1, no done pulse.
- acc_wr 0x05, then SUB operand 0x07 -> alu_load high for 1 cycle with bus_out=0x0007; acc=0xFE; flag_s=1, flag_z=0; done 3 cycles after accept.
- acc=0x5A, XOR operand 0x5A -> acc=0x00, flag_z=1, flag_s=0.
- acc=0x81, RAL count 3 -> acc sequence 0x03, 0x06, 0x0C; done after 3 EXEC cycles; flags z=0, s=0.
- acc=0x81, RAR count 0 -> single iteration, acc=0x40.
- acc=0x3C, CMA count 2 -> acc=0x3C.
- Back-to-back: cmd_valid held continuously with ADD 0x01 from acc=0xFF -> acc=0x00, z=1; second ADD accepted only after DONE -> acc=0x01.
- cmd_valid asserted during EXEC is not accepted.
- acc_wr during EXEC is ignored.
